// File: rtl/fp_accum.sv
// fp_accum: sequential IEEE-754 single-precision accumulator.
// Takes one operand per handshake and runs it through an
// IDLE -> ALIGN -> ADD -> NORM sequence, one cycle per state.
// Each frame closes with the element flagged in_last; its sum is then
// published on sum_FP with a one-cycle sum_vld pulse.
// The optional macro FP_ACC_SAT_EN makes exponent overflow saturate to
// +/- max finite. Without it, overflow gives +/-Inf, and an Inf
// accumulator holds its value until the frame ends.
module fp_accum #(
  parameter int unsigned COUNT_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_vld,
  input  logic [31:0]        in_FP,
  input  logic               in_last,
  output logic               in_rdy,
  output logic               sum_vld,
  output logic [31:0]        sum_FP,
  output logic [COUNT_W-1:0] n_acc,
  output logic               ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] ADD   = 2'd2;
  localparam logic [1:0] NORM  = 2'd3;

  logic [1:0]  state;
  logic [31:0] acc;
  logic [31:0] op_q;
  logic        last_q;

  // Extended magnitudes: hidden bit, 23 fraction bits, guard, round, sticky.
  logic [26:0] big_q;
  logic [26:0] small_q;
  logic        big_sign_q;
  logic        small_sign_q;
  logic [7:0]  exp_q;

  logic [27:0] sum_mag;
  logic        sum_sign;

  // ALIGN stage combinational signals
  logic [7:0]  acc_exp;
  logic [7:0]  op_exp;
  logic [26:0] acc_ext;
  logic [26:0] op_ext;
  logic        acc_sign;
  logic        op_sign;
  logic [26:0] big_ext;
  logic [26:0] small_ext;
  logic        big_sign;
  logic        small_sign;
  logic [7:0]  big_exp;
  logic [7:0]  small_exp;
  logic [7:0]  exp_diff;
  logic [26:0] small_shr;
  logic [26:0] shr_mask;
  logic [26:0] small_aligned;

  // ADD stage combinational signals
  logic [27:0] sum_next;
  logic        sign_next;

  // NORM stage combinational signals
  logic [4:0]        lead;
  logic [4:0]        lz_shift;
  logic [26:0]       norm_shifted;
  logic signed [9:0] norm_exp;
  logic [22:0]       frac;
  logic [31:0]       result;
  logic              ovf_hit;

  // Value produced whenever the exponent overflows.
  function automatic logic [31:0] ovf_result(input logic sign);
`ifdef FP_ACC_SAT_EN
    return {sign, 8'hFE, 23'h7FFFFF};
`else
    return {sign, 8'hFF, 23'h000000};
`endif
  endfunction

  // Ready only while idle and not being cleared or reset.
  always_comb begin
    in_rdy = (state == IDLE) && !clr && !rst;
  end

  // Pick the larger-exponent operand and shift the other one right, keeping a sticky bit.
  always_comb begin
    acc_exp  = acc[30:23];
    op_exp   = op_q[30:23];
    acc_ext  = (acc_exp == 8'd0) ? '0 : {1'b1, acc[22:0], 3'b000};
    op_ext   = (op_exp == 8'd0) ? '0 : {1'b1, op_q[22:0], 3'b000};
    acc_sign = (acc_exp != 8'd0) && acc[31];
    op_sign  = (op_exp != 8'd0) && op_q[31];
    if (op_exp > acc_exp) begin
      big_ext    = op_ext;
      big_sign   = op_sign;
      big_exp    = op_exp;
      small_ext  = acc_ext;
      small_sign = acc_sign;
      small_exp  = acc_exp;
    end else begin
      big_ext    = acc_ext;
      big_sign   = acc_sign;
      big_exp    = acc_exp;
      small_ext  = op_ext;
      small_sign = op_sign;
      small_exp  = op_exp;
    end
    exp_diff  = big_exp - small_exp;
    small_shr = small_ext >> exp_diff;
    shr_mask  = ~({27{1'b1}} << exp_diff);
    if (exp_diff >= 8'd27) begin
      small_aligned = {26'd0, |small_ext};
    end else begin
      small_aligned = {small_shr[26:1], small_shr[0] | (|(small_ext & shr_mask))};
    end
  end

  // Signed-magnitude add or subtract of the aligned operands.
  always_comb begin
    if (big_sign_q == small_sign_q) begin
      sum_next  = {1'b0, big_q} + {1'b0, small_q};
      sign_next = big_sign_q;
    end else if (big_q >= small_q) begin
      sum_next  = {1'b0, big_q} - {1'b0, small_q};
      sign_next = big_sign_q;
    end else begin
      sum_next  = {1'b0, small_q} - {1'b0, big_q};
      sign_next = small_sign_q;
    end
  end

  // Find the leading one below the carry bit.
  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum_mag[i]) begin
        lead = 5'(i);
      end
    end
  end

  // Normalize, truncate, and apply the zero, underflow, overflow and Inf rules.
  always_comb begin
    lz_shift     = 5'd26 - lead;
    norm_shifted = sum_mag[26:0] << lz_shift;
    if (sum_mag[27]) begin
      norm_exp = $signed({2'b00, exp_q}) + 10'sd1;
      frac     = sum_mag[26:4];
    end else begin
      norm_exp = $signed({2'b00, exp_q}) - $signed({5'b00000, lz_shift});
      frac     = 23'(norm_shifted >> 3);
    end
    ovf_hit = 1'b0;
    result  = '0;
`ifndef FP_ACC_SAT_EN
    if (acc[30:23] == 8'hFF) begin
      result = acc;
    end else
`endif
    if (op_q[30:23] == 8'hFF) begin
      result  = ovf_result(op_q[31]);
      ovf_hit = 1'b1;
    end else if (sum_mag == 28'd0) begin
      result = '0;
    end else if (norm_exp >= 10'sd255) begin
      result  = ovf_result(sum_sign);
      ovf_hit = 1'b1;
    end else if (norm_exp <= 10'sd0) begin
      result = '0;
    end else begin
      result = {sum_sign, norm_exp[7:0], frac};
    end
  end

  // Pipeline registers for the operand and the intermediate align/add results.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      last_q       <= 1'b0;
      big_q        <= '0;
      small_q      <= '0;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      exp_q        <= '0;
      sum_mag      <= '0;
      sum_sign     <= 1'b0;
    end else begin
      if (in_vld && in_rdy) begin
        op_q   <= in_FP;
        last_q <= in_last;
      end
      if (state == ALIGN) begin
        big_q        <= big_ext;
        small_q      <= small_aligned;
        big_sign_q   <= big_sign;
        small_sign_q <= small_sign;
        exp_q        <= big_exp;
      end
      if (state == ADD) begin
        sum_mag  <= sum_next;
        sum_sign <= sign_next;
      end
    end
  end

  // Sequencing, accumulator, counter, overflow flag and frame output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      n_acc   <= '0;
      ovf     <= 1'b0;
      sum_FP  <= '0;
      sum_vld <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      acc     <= '0;
      n_acc   <= '0;
      ovf     <= 1'b0;
      sum_vld <= 1'b0;
    end else begin
      sum_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (in_vld && in_rdy) begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          state <= ADD;
        end
        ADD: begin
          // The counter steps as NORM is entered, so it already includes this element during NORM.
          if (n_acc != '1) begin
            n_acc <= n_acc + 1'b1;
          end
          state <= NORM;
        end
        default: begin
          if (ovf_hit) begin
            ovf <= 1'b1;
          end
          if (last_q) begin
            sum_FP  <= result;
            sum_vld <= 1'b1;
            acc     <= '0;
            n_acc   <= '0;
          end else begin
            acc <= result;
          end
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
